// File: rtl/lib_uart_pkg.sv
// lib_uart: shared types and constants for the UART transmit path.
//
// Contents:
//   UART_TX_STATE   transmitter FSM states. PARITY is always declared so that
//                   the encoding does not change with the parity build option.
//   FRAME_BITS_8N1  bit periods per frame without parity (start+8+stop)
//   FRAME_BITS_8E1  bit periods per frame with even parity
//   even_parity()   parity bit that makes the total count of ones even
`ifndef LIB_UART_SV
`define LIB_UART_SV

package lib_uart;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } UART_TX_STATE;

    localparam int FRAME_BITS_8N1 = 10;
    localparam int FRAME_BITS_8E1 = 11;

    function automatic logic even_parity(input logic [7:0] data);
        return ^data;
    endfunction

endpackage

`endif

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: bit-period timer for the UART transmitter.
//
// A counter runs 0..CLKS_PER_BIT-1 and wraps. tick is high for the single
// cycle in which the counter holds CLKS_PER_BIT-1, i.e. the last cycle of a
// bit period. clear holds the counter at 0 so the first bit period after a
// frame is accepted is exactly CLKS_PER_BIT cycles long.
//
// Ports:
//   clk    system clock
//   reset  synchronous, active-high reset
//   clear  hold counter at 0
//   tick   one-cycle pulse on the last cycle of each bit period
module uart_baud_tick #(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic tick
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] count;

    // NOTE: sequential state is written with non-blocking assignments only, so
    // every register samples the pre-edge values of the others.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= '0;
        end else if (count == LAST) begin
            count <= '0;
        end else begin
            count <= count + CW'(1);
        end
    end

    assign tick = (count == LAST);

endmodule

// File: rtl/uart_tx_responder.sv
// uart_tx_responder: peripheral end of the CPU write channel.
//
// Accepts one byte per request while idle and serializes it LSB first as an
// asynchronous 8N1 frame (8E1 when UART_TX_PARITY_EN is defined). w_busy is
// high from the edge that accepts a byte until the edge that ends the stop
// bit; requests seen while busy are dropped.
//
// Build option:
//   UART_TX_PARITY_EN  insert an even-parity bit between data and stop
//
// Parameters:
//   CLK_FREQ   system clock in Hz
//   BAUD_RATE  serial bit rate; CLK_FREQ / BAUD_RATE must be at least 2
//
// Ports:
//   clk      system clock
//   reset    synchronous, active-high reset
//   w_req    write request (pulse or level), sampled only in IDLE
//   w_data   byte to send, valid with w_req
//   w_busy   frame in progress
//   uart_tx  serial output, idle high
module uart_tx_responder
    import lib_uart::*;
#(
    parameter int CLK_FREQ  = 27000000,
    parameter int BAUD_RATE = 115200
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       w_req,
    input  logic [7:0] w_data,
    output logic       w_busy,
    output logic       uart_tx
);

    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;

    UART_TX_STATE state;
    logic [2:0]   bit_idx;
    logic [7:0]   shift;
    logic         tick;

    // Holding the timer clear throughout IDLE means it starts from 0 on the
    // cycle after acceptance, so the start bit lasts a full bit period.
    uart_baud_tick #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud_tick (
        .clk  (clk),
        .reset(reset),
        .clear(state == IDLE),
        .tick (tick)
    );

    // uart_tx and w_busy are registered so the line is glitch-free and each
    // new level appears on the edge that enters the corresponding state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            bit_idx <= 3'd0;
            shift   <= 8'h00;
            uart_tx <= 1'b1;
            w_busy  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (w_req) begin
                        // Latched copy: later changes on w_data cannot
                        // disturb the frame in flight.
                        shift   <= w_data;
                        bit_idx <= 3'd0;
                        uart_tx <= 1'b0;
                        w_busy  <= 1'b1;
                        state   <= START;
                    end
                end

                START: begin
                    if (tick) begin
                        uart_tx <= shift[0];
                        bit_idx <= 3'd0;
                        state   <= DATA;
                    end
                end

                DATA: begin
                    if (tick) begin
                        if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                            uart_tx <= even_parity(shift);
                            state   <= PARITY;
`else
                            uart_tx <= 1'b1;
                            state   <= STOP;
`endif
                        end else begin
                            uart_tx <= shift[bit_idx + 3'd1];
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end
                end

`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    if (tick) begin
                        uart_tx <= 1'b1;
                        state   <= STOP;
                    end
                end
`endif

                STOP: begin
                    if (tick) begin
                        w_busy <= 1'b0;
                        state  <= IDLE;
                    end
                end

                // Unused encodings (and PARITY when parity is not built in)
                // fall back to a clean idle line.
                default: begin
                    uart_tx <= 1'b1;
                    w_busy  <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_responder.sv
// tb_uart_tx_responder: directed self-checking bench for uart_tx_responder
// with CLK_FREQ=16, BAUD_RATE=4 (4 clocks per bit). Inputs are driven and
// outputs sampled on the falling edge; the DUT acts on the rising edge.
module tb_uart_tx_responder;

    localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif

    logic       clk;
    logic       reset;
    logic       w_req;
    logic [7:0] w_data;
    logic       w_busy;
    logic       uart_tx;

    int tests_run = 0;
    int tests_failed = 0;

    uart_tx_responder #(
        .CLK_FREQ (16),
        .BAUD_RATE(4)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .w_req  (w_req),
        .w_data (w_data),
        .w_busy (w_busy),
        .uart_tx(uart_tx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_idle(input string tag, input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            check({tag, " tx"}, 32'(uart_tx), 32'd1);
            check({tag, " busy"}, 32'(w_busy), 32'd0);
        end
    endtask

    // Called at a falling edge with the DUT idle. Requests byte d, then checks
    // every cycle of the frame and the first idle cycle after it. At cycle
    // inj_cycle w_data is changed to inj_data and w_req raised; with hold=0 the
    // request is a one-cycle pulse, with hold=1 w_req stays high throughout.
    task automatic run_frame(input logic [7:0] d, input int inj_cycle,
                             input logic [7:0] inj_data, input bit hold);
        logic [10:0] exp_bits;
        exp_bits = '1;
        exp_bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) exp_bits[1 + i] = d[i];
`ifdef UART_TX_PARITY_EN
        exp_bits[9] = ^d;
`endif
        w_req  = 1'b1;
        w_data = d;
        @(negedge clk);
        for (int c = 0; c < NBITS * CPB; c++) begin
            check($sformatf("%h tx c%0d", d, c), 32'(uart_tx), 32'(exp_bits[c / CPB]));
            check($sformatf("%h busy c%0d", d, c), 32'(w_busy), 32'd1);
            if (c == 0 && !hold) w_req = 1'b0;
            if (c == inj_cycle) begin
                w_req  = 1'b1;
                w_data = inj_data;
            end
            if (c == inj_cycle + 1 && !hold) w_req = 1'b0;
            @(negedge clk);
        end
        check($sformatf("%h end busy", d), 32'(w_busy), 32'd0);
        check($sformatf("%h end tx", d), 32'(uart_tx), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset  = 1'b1;
        w_req  = 1'b0;
        w_data = 8'h00;

        // Reset held for three edges, then a quiet line.
        repeat (3) @(negedge clk);
        check("rst tx", 32'(uart_tx), 32'd1);
        check("rst busy", 32'(w_busy), 32'd0);
        reset = 1'b0;
        check_idle("idle", 20);

        // Reset and request together: the request is dropped.
        reset  = 1'b1;
        w_req  = 1'b1;
        w_data = 8'hAA;
        @(negedge clk);
        reset = 1'b0;
        w_req = 1'b0;
        check_idle("rst+req", 6);

        // Single byte: 0,1,0,1,0,0,1,0,1,1 (plus parity when enabled).
        run_frame(8'hA5, -1, 8'h00, 1'b0);
        check_idle("after a5", 3);

        // Request while busy is ignored and w_data change has no effect.
        run_frame(8'h3C, 12, 8'hFF, 1'b0);
        check_idle("after 3c", 8);

        // Back-to-back with w_req held: exactly one idle cycle between frames.
        run_frame(8'h00, 5, 8'h01, 1'b1);
        run_frame(8'h01, -1, 8'h00, 1'b0);
        check_idle("after 01", 3);

        // Reset during data bit 3 of 8'h0F (cycles 16..19 of the frame).
        w_req  = 1'b1;
        w_data = 8'h0F;
        @(negedge clk);
        w_req = 1'b0;
        repeat (17) @(negedge clk);
        check("mid busy", 32'(w_busy), 32'd1);
        check("mid tx", 32'(uart_tx), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        check("mid rst tx", 32'(uart_tx), 32'd1);
        check("mid rst busy", 32'(w_busy), 32'd0);
        reset = 1'b0;
        check_idle("after mid rst", 8);
        run_frame(8'h55, -1, 8'h00, 1'b0);
        check_idle("after 55", 2);

        // 8'h07: three ones, so the even-parity bit is 1 when enabled.
        run_frame(8'h07, -1, 8'h00, 1'b0);
        check_idle("after 07", 2);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
